// File: rtl/pair_detect_sched.sv
// rtl/pair_detect_sched.sv - round-robin scheduler feeding a shared serial equal-pair detector
// Two requesters share one LSB-first Mealy "00"/"11" pair detector; each job returns a match count.
module pair_detect_sched #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             ser_bit,
  output logic             match,
  output logic             done,
  output logic [CW-1:0]    count,
  output logic             owner
);

  localparam int BW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {D_IDLE, D_LAST1, D_LAST0} dstate_t;

  state_t           state;
  dstate_t          dstate;
  dstate_t          det_next;
  logic             det_out;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bitcnt;
  logic             last_owner;
  logic             winner;

  // On a tie the requester that did not own the previous job wins.
  always_comb begin
    winner = (req0 && req1) ? ~last_owner : req1;
  end

  always_comb begin
    det_next = D_IDLE;
    det_out  = 1'b0;
    case (dstate)
      D_IDLE:  det_next = shreg[0] ? D_LAST1 : D_LAST0;
      D_LAST1: begin
        det_next = shreg[0] ? D_IDLE : D_LAST0;
        det_out  = shreg[0];
      end
      D_LAST0: begin
        det_next = shreg[0] ? D_LAST1 : D_IDLE;
        det_out  = ~shreg[0];
      end
      default: det_next = D_IDLE;
    endcase
  end

  assign ser_bit = (state == SHIFT) && shreg[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dstate     <= D_IDLE;
      shreg      <= '0;
      bitcnt     <= '0;
      last_owner <= 1'b1;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      busy       <= 1'b0;
      match      <= 1'b0;
      done       <= 1'b0;
      count      <= '0;
      owner      <= 1'b0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      match <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            shreg      <= winner ? data1 : data0;
            gnt0       <= ~winner;
            gnt1       <= winner;
            owner      <= winner;
            last_owner <= winner;
            busy       <= 1'b1;
            count      <= '0;
            bitcnt     <= '0;
            dstate     <= D_IDLE;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          shreg  <= shreg >> 1;
          bitcnt <= bitcnt + BW'(1);
          dstate <= det_next;
          match  <= det_out;
          if (det_out) count <= count + CW'(1);
          if (bitcnt == BW'(WIDTH - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pair_detect_sched.sv
// tb/tb_pair_detect_sched.sv - randomized and directed bench for pair_detect_sched
module tb_pair_detect_sched;

  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1;
  logic [WIDTH-1:0] data0, data1;
  logic             gnt0, gnt1, busy, ser_bit, match, done, owner;
  logic [CW-1:0]    count;

  int checks   = 0;
  int failures = 0;

  // Reference state: outstanding requests, their words, and the last job owner.
  logic             pend0, pend1;
  logic [WIDTH-1:0] w0, w1;
  logic             last_m;

  pair_detect_sched #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .ser_bit(ser_bit),
    .match(match), .done(done), .count(count), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scan the word for non-overlapping adjacent equal bits, LSB first.
  function automatic void pair_model(input logic [WIDTH-1:0] w,
                                     output logic [WIDTH-1:0] m, output int cnt);
    logic have, prev;
    have = 1'b0; prev = 1'b0; m = '0; cnt = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (have && (w[i] == prev)) begin
        m[i] = 1'b1; cnt++; have = 1'b0;
      end else begin
        have = 1'b1; prev = w[i];
      end
    end
  endfunction

  task automatic drive_reqs();
    req0 = pend0; data0 = w0;
    req1 = pend1; data1 = w1;
  endtask

  // Expects a grant at the next edge, then follows the job to completion.
  task automatic run_job(input bit hold);
    logic             win;
    logic [WIDTH-1:0] w, m;
    int               cnt;
    win = (pend0 && pend1) ? ~last_m : pend1;
    w   = win ? w1 : w0;
    pair_model(w, m, cnt);
    drive_reqs();
    step();
    check("gnt0", gnt0, !win);
    check("gnt1", gnt1, win);
    check("busy_at_gnt", busy, 1);
    check("owner_at_gnt", owner, win);
    check("count_cleared", count, 0);
    check("ser_bit0", ser_bit, w[0]);
    last_m = win;
    if (!hold) begin
      if (win) pend1 = 1'b0; else pend0 = 1'b0;
      drive_reqs();
    end
    for (int k = 0; k < WIDTH; k++) begin
      step();
      check("match", match, m[k]);
      check("no_gnt_busy", {gnt0, gnt1}, 2'b00);
      check("busy", busy, 1);
      if (k < WIDTH - 1) begin
        check("ser_bit", ser_bit, w[k+1]);
        check("done_early", done, 0);
      end
    end
    check("done", done, 1);
    check("count", count, cnt);
    check("owner", owner, win);
    check("ser_bit_done", ser_bit, 0);
    step();
    check("done_clear", done, 0);
    check("busy_clear", busy, 0);
    check("count_hold", count, cnt);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_outs"}, {gnt0, gnt1, busy, ser_bit, match, done, owner}, 7'b0);
    check({tag, "_count"}, count, 0);
  endtask

  initial begin
    pend0 = 0; pend1 = 0; w0 = '0; w1 = '0; last_m = 1'b1;
    rst = 1'b1; drive_reqs();
    step(); step();
    check_reset_values("reset");
    rst = 1'b0;
    step();

    // Directed words.
    pend0 = 1; w0 = 8'hFF; run_job(0);
    pend1 = 1; w1 = 8'hAA; run_job(0);
    pend0 = 1; w0 = 8'h36; run_job(0);

    // Tie straight after reset: requester 0 first, then 1, then 0 wins the next tie.
    rst = 1'b1; step(); rst = 1'b0; last_m = 1'b1;
    check_reset_values("reset2");
    pend0 = 1; w0 = 8'h5C; pend1 = 1; w1 = 8'hC3;
    run_job(0);
    run_job(0);
    check("owner_after_tie", owner, 1);
    pend0 = 1; w0 = 8'h01; pend1 = 1; w1 = 8'h80;
    run_job(0);
    check("tie2_owner", owner, 0);
    run_job(0);

    // Reset mid-job discards the word.
    pend0 = 1; w0 = 8'h0F; drive_reqs();
    step();
    check("gnt0_pre_rst", gnt0, 1);
    pend0 = 0; drive_reqs();
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1;
    step();
    check_reset_values("midjob_rst");
    rst = 1'b0;
    for (int k = 0; k < WIDTH + 2; k++) begin
      step();
      check("no_done_after_rst", {done, gnt0, gnt1}, 3'b000);
    end
    last_m = 1'b1;
    pend1 = 1; w1 = 8'h0F; run_job(0);

    // Requester 0 holds req through a whole job: regranted at E(WIDTH+2).
    pend0 = 1; w0 = 8'h99; run_job(1);
    run_job(0);

    // Randomized traffic.
    for (int j = 0; j < 40; j++) begin
      if (!pend0 && ($urandom_range(1) == 1)) begin pend0 = 1; w0 = WIDTH'($urandom); end
      if (!pend1 && ($urandom_range(1) == 1)) begin pend1 = 1; w1 = WIDTH'($urandom); end
      if (!pend0 && !pend1) begin pend1 = 1; w1 = WIDTH'($urandom); end
      run_job(0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
